// File: rtl/cim_accumulator.sv
// Signed-magnitude product accumulator: saturating sum of len products, sticky ovf; result 1 cycle after last product.
// Backpressure: result held in HOLD until out_ready, inputs ignored meanwhile; next frame starts the cycle after acceptance.
module cim_accumulator #(
    parameter int DIN_BIT_WIDTH = 18,
    parameter int ACC_LEN_WIDTH = 3,
    parameter int ACC_BIT_WIDTH = DIN_BIT_WIDTH + ACC_LEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ACC_LEN_WIDTH-1:0] len,
    input  logic                     in_valid,
    input  logic [DIN_BIT_WIDTH-1:0] din,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_BIT_WIDTH-1:0] dout,
    output logic                     ovf
);

    localparam int MAG_W = DIN_BIT_WIDTH - 1;
    localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE = 1;
    localparam logic [ACC_BIT_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_BIT_WIDTH-1){1'b1}}};
    localparam logic [ACC_BIT_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [ACC_BIT_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_LEN_WIDTH-1:0] len_q, len_d;
    logic [ACC_BIT_WIDTH-1:0] dout_q, dout_d;
    logic                     ovf_q, ovf_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;

    logic [ACC_BIT_WIDTH:0]   mag_ext, val_ext, sum;
    logic [ACC_BIT_WIDTH-1:0] sat_val;
    logic                     sat_hit;

    // One guard bit is enough: |product| < 2^(ACC_BIT_WIDTH-1), so the sum never wraps the wide form.
    always_comb begin
        mag_ext = '0;
        mag_ext[MAG_W-1:0] = din[MAG_W-1:0];
        val_ext = din[DIN_BIT_WIDTH-1] ? ('0 - mag_ext) : mag_ext;
        sum     = {acc_q[ACC_BIT_WIDTH-1], acc_q} + val_ext;
        sat_hit = sum[ACC_BIT_WIDTH] != sum[ACC_BIT_WIDTH-1];
        if (sat_hit) begin
            sat_val = sum[ACC_BIT_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_val = sum[ACC_BIT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sat_val;
                    cnt_d = cnt_q + LEN_ONE;
                    if (sat_hit) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == (len_q - LEN_ONE)) begin
                        dout_d      = sat_val;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cim_accumulator.sv
// Bench for cim_accumulator: a default-width instance and a 19-bit accumulator instance share stimulus.
module tb_cim_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  len;
    logic        in_valid;
    logic [17:0] din;
    logic        out_ready;

    logic        busy1, ov1, ovf1;
    logic [20:0] dout1;
    logic        busy2, ov2, ovf2;
    logic [18:0] dout2;

    int checks = 0;
    int errors = 0;

    logic [17:0] prod_q[$];
    int          gap_q[$];

    always #5 clk = ~clk;

    cim_accumulator dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .din(din),
        .busy(busy1), .out_valid(ov1), .out_ready(out_ready), .dout(dout1), .ovf(ovf1)
    );

    cim_accumulator #(.ACC_BIT_WIDTH(19)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .din(din),
        .busy(busy2), .out_valid(ov2), .out_ready(out_ready), .dout(dout2), .ovf(ovf2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum of signed-magnitude values, clamped after every product.
    function automatic void model(input int aw, output longint s, output bit o);
        longint mx, mn, v;
        logic [17:0] p;
        mx = (longint'(1) <<< (aw - 1)) - 1;
        mn = -(longint'(1) <<< (aw - 1));
        s = 0;
        o = 1'b0;
        foreach (prod_q[i]) begin
            p = prod_q[i];
            v = longint'(p[16:0]);
            if (p[17]) v = -v;
            s = s + v;
            if (s > mx) begin
                s = mx;
                o = 1'b1;
            end else if (s < mn) begin
                s = mn;
                o = 1'b1;
            end
        end
    endfunction

    // Drives one frame from prod_q/gap_q, checks latency, held result and acceptance on both instances.
    task automatic run_frame(input string tag, input int ready_delay, input bit noise);
        longint s1, s2;
        bit o1, o2;
        logic [20:0] e1;
        logic [18:0] e2;
        int n;
        n = prod_q.size();
        model(21, s1, o1);
        model(19, s2, o2);
        e1 = s1[20:0];
        e2 = s2[18:0];
        start = 1'b1;
        len = n[2:0];
        step();
        start = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b/%b expected 1/1", tag, busy1, busy2);
        end
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                in_valid = 1'b0;
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    len = 3'($urandom);
                    din = 18'($urandom);
                end
                step();
                checks++;
                if (ov1 !== 1'b0 || busy1 !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap_state: got out_valid=%b busy=%b expected 0/1", tag, ov1, busy1);
                end
            end
            start = 1'b0;
            in_valid = 1'b1;
            din = prod_q[i];
            if (i == n - 1 && ready_delay == 0) out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            if (i < n - 1) begin
                checks++;
                if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_out_valid: got %b/%b expected 0/0", tag, ov1, ov2);
                end
            end
        end
        checks++;
        if (ov1 !== 1'b1 || dout1 !== e1 || ovf1 !== o1) begin
            errors++;
            $display("FAIL %s result21: got v=%b dout=%h ovf=%b expected v=1 dout=%h ovf=%b",
                     tag, ov1, dout1, ovf1, e1, o1);
        end
        checks++;
        if (ov2 !== 1'b1 || dout2 !== e2 || ovf2 !== o2) begin
            errors++;
            $display("FAIL %s result19: got v=%b dout=%h ovf=%b expected v=1 dout=%h ovf=%b",
                     tag, ov2, dout2, ovf2, e2, o2);
        end
        for (int h = 0; h < ready_delay; h++) begin
            if (noise) begin
                start = 1'b1;
                len = 3'($urandom_range(1, 7));
                in_valid = 1'b1;
                din = 18'($urandom);
            end
            step();
            checks++;
            if (ov1 !== 1'b1 || dout1 !== e1 || ovf1 !== o1 || busy1 !== 1'b1 ||
                ov2 !== 1'b1 || dout2 !== e2 || ovf2 !== o2) begin
                errors++;
                $display("FAIL %s hold_stable: got v=%b dout=%h busy=%b expected v=1 dout=%h busy=1",
                         tag, ov1, dout1, busy1, e1);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (ov1 !== 1'b0 || busy1 !== 1'b0 || ov2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL %s accept_idle: got v=%b busy=%b expected 0/0", tag, ov1, busy1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        len = 3'd0;
        in_valid = 1'b0;
        din = '0;
        out_ready = 1'b0;
        #12;
        checks++;
        if ({busy1, ov1, dout1, ovf1} !== '0 || {busy2, ov2, dout2, ovf2} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h/%h expected 0", {busy1, ov1, dout1, ovf1}, {busy2, ov2, dout2, ovf2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        prod_q = '{18'h00005, 18'h20003, 18'h0000A};
        gap_q  = '{0, 0, 0};
        run_frame("basic", 0, 1'b0);
        checks++;
        if (dout1 !== 21'd12 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_value: got %0d ovf=%b expected 12 ovf=0", dout1, ovf1);
        end
    endtask

    task automatic test_gapped();
        prod_q = '{18'h20000, 18'h20007};
        gap_q  = '{0, 2};
        run_frame("gapped", 1, 1'b0);
        checks++;
        if (dout1 !== 21'h1FFFF9 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL gapped_value: got %h ovf=%b expected 1ffff9 ovf=0", dout1, ovf1);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        prod_q = '{18'h00005, 18'h20003, 18'h0000A};
        gap_q  = '{0, 0, 0};
        run_frame("backpressure", 4, 1'b1);
        checks++;
        if (dout1 !== 21'd12) begin
            errors++;
            $display("FAIL backpressure_value: got %0d expected 12", dout1);
        end
    endtask

    task automatic test_saturation();
        prod_q = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
        gap_q  = '{0, 1, 0};
        run_frame("saturation", 2, 1'b0);
        checks++;
        if (dout2 !== 19'd262143 || ovf2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_value: got %0d ovf=%b expected 262143 ovf=1", dout2, ovf2);
        end
        prod_q = '{18'h00001};
        gap_q  = '{0};
        run_frame("sat_follow", 0, 1'b0);
        checks++;
        if (dout2 !== 19'd1 || ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_followup: got %0d ovf=%b expected 1 ovf=0", dout2, ovf2);
        end
    endtask

    task automatic test_len_boundary();
        start = 1'b1;
        len = 3'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy1 !== 1'b0 || ov1 !== 1'b0 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL len0_ignored: got busy=%b v=%b expected 0/0", busy1, ov1);
            end
            in_valid = 1'b1;
            din = 18'h00003;
            step();
        end
        in_valid = 1'b0;
        prod_q = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
        gap_q  = '{0, 0, 1, 0, 0, 2, 0};
        run_frame("len7", 1, 1'b0);
        checks++;
        if (dout1 !== 21'd917497 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL len7_value: got %0d ovf=%b expected 917497 ovf=0", dout1, ovf1);
        end
    endtask

    task automatic test_reset_midframe();
        start = 1'b1;
        len = 3'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        din = 18'h00005;
        step();
        din = 18'h00007;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, ov1, dout1, ovf1} !== '0 || {busy2, ov2, dout2, ovf2} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got %h/%h expected 0", {busy1, ov1, dout1, ovf1}, {busy2, ov2, dout2, ovf2});
        end
        #2;
        rst_n = 1'b1;
        step();
        prod_q = '{18'h20004};
        gap_q  = '{0};
        run_frame("after_reset", 0, 1'b0);
        checks++;
        if (dout1 !== 21'h1FFFFC) begin
            errors++;
            $display("FAIL after_reset_value: got %h expected 1ffffc", dout1);
        end
    endtask

    task automatic test_random();
        logic [17:0] p;
        int n;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 7);
            prod_q.delete();
            gap_q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: p = 18'h1FFFF;
                    1: p = 18'h3FFFF;
                    2: p = 18'h20000;
                    default: p = 18'($urandom);
                endcase
                prod_q.push_back(p);
                gap_q.push_back($urandom_range(0, 3));
            end
            run_frame("random", $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back_backpressure();
        test_saturation();
        test_len_boundary();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
